// File: rtl/aes_block_packer_pkg.sv
// rtl/aes_block_packer_pkg.sv - shared types and sizes for the AES block packer and its output slice.
package aes_block_packer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } aes_packer_state_e;

  localparam int AES_BLOCK_WIDTH     = 128;
  localparam int AES_WORDS_PER_BLOCK = 4;
  localparam int AES_WORD_WIDTH      = AES_BLOCK_WIDTH / AES_WORDS_PER_BLOCK;

endpackage

// File: rtl/aes_block_out_reg.sv
// rtl/aes_block_out_reg.sv - single-entry block register slice with last flag.
// A new block may load in the same cycle the held one is accepted, so there is no bubble.
module aes_block_out_reg
  import aes_block_packer_pkg::*;
#(
  parameter int DATA_WIDTH = AES_BLOCK_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_can_load
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs stream words into AES blocks and tracks the job length.
// Fill register gathers the first words; the final word goes straight into the output slice.
module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int WORD_WIDTH      = AES_WORD_WIDTH,
  parameter int WORDS_PER_BLOCK = AES_WORDS_PER_BLOCK,
  parameter int BLOCK_WIDTH     = WORD_WIDTH * WORDS_PER_BLOCK,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   n_blocks_i,
  input  logic [WORD_WIDTH-1:0]  word_data_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  output logic [BLOCK_WIDTH-1:0] block_data_o,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  output logic                   block_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   blocks_out_o
);

  localparam int WCNT_WIDTH = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [WCNT_WIDTH-1:0] LAST_SLOT = WCNT_WIDTH'(WORDS_PER_BLOCK - 1);

  aes_packer_state_e      r_state;
  logic [WCNT_WIDTH-1:0]  r_wcnt;
  logic [CNT_WIDTH-1:0]   r_n_blocks;
  logic [CNT_WIDTH-1:0]   r_packed;
  logic [CNT_WIDTH-1:0]   r_blocks_out;
  logic [BLOCK_WIDTH-1:0] r_fill;
  logic                   r_done;

  logic                   w_rst;
  logic                   w_last_slot;
  logic                   w_can_load;
  logic                   w_out_valid;
  logic                   w_out_fire;
  logic                   w_word_ready;
  logic                   w_word_fire;
  logic                   w_load;
  logic                   w_load_last;
  logic [BLOCK_WIDTH-1:0] w_full;

  assign w_rst       = !rst_ni || clear_i;
  assign w_last_slot = (r_wcnt == LAST_SLOT);
  assign w_out_fire  = w_out_valid && block_ready_i;

  // The last word may only be taken when the output slice can absorb the block this edge.
  assign w_word_ready = enable_i && (r_state == RUN) && (!w_last_slot || w_can_load);
  assign w_word_fire  = w_word_ready && word_valid_i;
  assign w_load       = w_word_fire && w_last_slot;
  assign w_load_last  = ((r_packed + CNT_WIDTH'(1)) == r_n_blocks);

  always_comb begin
    w_full                 = r_fill;
    w_full[WORD_WIDTH-1:0] = word_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_fill <= '0;
    end else if (w_word_fire && !w_last_slot) begin
      for (int k = 0; k < WORDS_PER_BLOCK - 1; k++) begin
        if (r_wcnt == WCNT_WIDTH'(k)) begin
          r_fill[BLOCK_WIDTH-1-WORD_WIDTH*k -: WORD_WIDTH] <= word_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_n_blocks   <= '0;
      r_packed     <= '0;
      r_blocks_out <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_out_fire) begin
        r_blocks_out <= r_blocks_out + CNT_WIDTH'(1);
      end
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_n_blocks   <= n_blocks_i;
            r_wcnt       <= '0;
            r_packed     <= '0;
            r_blocks_out <= '0;
            r_state      <= (n_blocks_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_word_fire) begin
            if (w_last_slot) begin
              r_wcnt   <= '0;
              r_packed <= r_packed + CNT_WIDTH'(1);
              if (w_load_last) begin
                r_state <= DRAIN;
              end
            end else begin
              r_wcnt <= r_wcnt + WCNT_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  aes_block_out_reg #(
    .DATA_WIDTH(BLOCK_WIDTH)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .i_load     (w_load),
    .i_data     (w_full),
    .i_last     (w_load_last),
    .i_ready    (block_ready_i),
    .o_valid    (w_out_valid),
    .o_data     (block_data_o),
    .o_last     (block_last_o),
    .o_can_load (w_can_load)
  );

  assign word_ready_o  = w_word_ready;
  assign block_valid_o = w_out_valid;
  assign busy_o        = (r_state == RUN) || (r_state == DRAIN);
  assign done_o        = r_done;
  assign blocks_out_o  = r_blocks_out;

endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - scoreboard bench for aes_block_packer.
module tb_aes_block_packer;

  localparam int WW  = 32;
  localparam int WPB = 4;
  localparam int BW  = WW * WPB;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          enable_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] n_blocks_i = '0;
  logic [WW-1:0] word_data_i = '0;
  logic          word_valid_i = 1'b0;
  logic          word_ready_o;
  logic [BW-1:0] block_data_o;
  logic          block_valid_o;
  logic          block_ready_i = 1'b0;
  logic          block_last_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] blocks_out_o;

  always #5 clk = ~clk;

  aes_block_packer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .enable_i     (enable_i),
    .start_i      (start_i),
    .n_blocks_i   (n_blocks_i),
    .word_data_i  (word_data_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .block_data_o (block_data_o),
    .block_valid_o(block_valid_o),
    .block_ready_i(block_ready_i),
    .block_last_o (block_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .blocks_out_o (blocks_out_o)
  );

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [WW-1:0] wq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wfire_cnt, first_wfire, last_wfire, first_valid, hs_cnt, last_hs;
  bit rnd_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    wfire_cnt = 0; first_wfire = -1; last_wfire = -1;
    first_valid = -1; hs_cnt = 0; last_hs = -1;
  endtask

  // Monitor: samples on the falling edge what the next rising edge will transfer.
  always @(negedge clk) begin
    if (word_valid_i && word_ready_o) begin
      if (wfire_cnt == 0) first_wfire = cyc;
      last_wfire = cyc;
      wfire_cnt++;
    end
    if (block_valid_o && first_valid < 0) first_valid = cyc;
    if (block_valid_o && block_ready_i) begin
      last_hs = cyc;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_block: got %0h expected no block", block_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("block_data", block_data_o, mon_e.data);
        chk("block_last", BW'(block_last_o), BW'(mon_e.last));
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_mode) begin
      block_ready_i = ($urandom % 3) != 0;
      enable_i      = ($urandom % 5) != 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int n, output int sc);
    n_blocks_i = CW'(n);
    start_i = 1'b1;
    sc = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic gen_words(input int cnt);
    wq.delete();
    for (int i = 0; i < cnt; i++) wq.push_back($urandom);
  endtask

  task automatic push_blocks(input int nb, input int njob);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < WPB; j++) e.data = (e.data << WW) | BW'(wq[b*WPB + j]);
      e.last = (b == njob - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [WW-1:0] d, output bit ok);
    bit f;
    word_valid_i = 1'b1;
    word_data_i = d;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      f = word_ready_o;
      tick();
      if (f) begin
        ok = 1'b1;
        break;
      end
    end
    word_valid_i = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_word_timeout: got no ready expected ready within 200 cycles");
    end
  endtask

  task automatic send_all(input int cnt, input bit rnd);
    bit ok;
    for (int i = 0; i < cnt; i++) begin
      if (rnd && ($urandom % 4) == 0) tick();
      send_word(wq[i], ok);
      if (!ok) break;
    end
  endtask

  task automatic wait_done(input int budget, output int dc);
    bit seen = 1'b0;
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        dc = cyc;
        break;
      end
    end
    chk("done_seen", BW'(seen), BW'(1));
    if (seen) begin
      @(negedge clk);
      chk("done_one_cycle", BW'(done_o), BW'(0));
    end
    tick();
  endtask

  initial begin
    int sc, dc, n;
    bit ok;
    logic [BW-1:0] b2;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", BW'(block_valid_o), BW'(0));
    chk("rst_last", BW'(block_last_o), BW'(0));
    chk("rst_word_ready", BW'(word_ready_o), BW'(0));
    chk("rst_busy", BW'(busy_o), BW'(0));
    chk("rst_done", BW'(done_o), BW'(0));
    chk("rst_blocks_out", BW'(blocks_out_o), BW'(0));
    chk("rst_data", block_data_o, BW'(0));
    rst_ni = 1'b1;
    enable_i = 1'b1;
    block_ready_i = 1'b1;
    tick();

    // Single block with the reference words.
    clear_stats();
    wq.delete();
    wq.push_back(32'h00112233); wq.push_back(32'h44556677);
    wq.push_back(32'h8899AABB); wq.push_back(32'hCCDDEEFF);
    push_blocks(1, 1);
    chk("single_exp_block", exp_q[0].data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    start_job(1, sc);
    send_all(4, 1'b0);
    wait_done(50, dc);
    chk("single_valid_latency", BW'(first_valid), BW'(sc + 5));
    chk("single_done_timing", BW'(dc), BW'(last_hs + 2));
    chk("single_blocks_out", BW'(blocks_out_o), BW'(1));

    // Streaming three blocks back to back.
    clear_stats();
    gen_words(12);
    push_blocks(3, 3);
    start_job(3, sc);
    send_all(12, 1'b0);
    wait_done(50, dc);
    chk("stream_words", BW'(wfire_cnt), BW'(12));
    chk("stream_first_word", BW'(first_wfire), BW'(sc + 1));
    chk("stream_consecutive", BW'(last_wfire - first_wfire), BW'(11));
    chk("stream_first_valid", BW'(first_valid), BW'(sc + 5));
    chk("stream_blocks", BW'(hs_cnt), BW'(3));
    chk("stream_blocks_out", BW'(blocks_out_o), BW'(3));

    // Backpressure on the final word of block 2.
    clear_stats();
    gen_words(8);
    push_blocks(2, 2);
    b2 = exp_q[1].data;
    block_ready_i = 1'b0;
    start_job(2, sc);
    send_all(7, 1'b0);
    word_valid_i = 1'b1;
    word_data_i = wq[7];
    tick();
    @(negedge clk);
    chk("bp_word_ready_low", BW'(word_ready_o), BW'(0));
    chk("bp_block1_held", BW'(block_valid_o), BW'(1));
    tick();
    block_ready_i = 1'b1;
    #1;
    chk("bp_word_ready_comb", BW'(word_ready_o), BW'(1));
    send_word(wq[7], ok);
    chk("bp_no_bubble", BW'(block_valid_o), BW'(1));
    chk("bp_block2_data", block_data_o, b2);
    wait_done(50, dc);
    chk("bp_blocks_out", BW'(blocks_out_o), BW'(2));

    // Zero-length job.
    clear_stats();
    word_valid_i = 1'b1;
    word_data_i = $urandom;
    start_job(0, sc);
    wait_done(20, dc);
    word_valid_i = 1'b0;
    chk("zero_done_timing", BW'(dc), BW'(sc + 2));
    chk("zero_no_words", BW'(wfire_cnt), BW'(0));
    chk("zero_no_valid", BW'(first_valid), BW'(-1));
    chk("zero_blocks_out", BW'(blocks_out_o), BW'(0));

    // Soft clear after six words, then a fresh job.
    clear_stats();
    gen_words(6);
    push_blocks(1, 4);
    start_job(4, sc);
    send_all(6, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_valid", BW'(block_valid_o), BW'(0));
    chk("clr_last", BW'(block_last_o), BW'(0));
    chk("clr_word_ready", BW'(word_ready_o), BW'(0));
    chk("clr_busy", BW'(busy_o), BW'(0));
    chk("clr_data", block_data_o, BW'(0));
    chk("clr_blocks_out", BW'(blocks_out_o), BW'(0));
    chk("clr_first_block_out", BW'(hs_cnt), BW'(1));
    gen_words(4);
    push_blocks(1, 1);
    start_job(1, sc);
    send_all(4, 1'b0);
    wait_done(50, dc);
    chk("clr_fresh_blocks_out", BW'(blocks_out_o), BW'(1));

    // Start ignored while running, then reset with a block held.
    clear_stats();
    gen_words(4);
    block_ready_i = 1'b0;
    start_job(2, sc);
    send_all(2, 1'b0);
    n_blocks_i = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_ignored_busy", BW'(busy_o), BW'(1));
    wq.delete(0);
    wq.delete(0);
    send_all(2, 1'b0);
    chk("rstmid_valid_before", BW'(block_valid_o), BW'(1));
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rstmid_valid", BW'(block_valid_o), BW'(0));
    chk("rstmid_busy", BW'(busy_o), BW'(0));
    chk("rstmid_data", block_data_o, BW'(0));
    block_ready_i = 1'b1;
    tick();

    // Randomized jobs with random enable and output backpressure.
    rnd_mode = 1'b1;
    for (int j = 0; j < 6; j++) begin
      clear_stats();
      n = $urandom_range(1, 6);
      gen_words(n * WPB);
      push_blocks(n, n);
      start_job(n, sc);
      send_all(n * WPB, 1'b1);
      wait_done(4000, dc);
      chk("rnd_blocks_out", BW'(blocks_out_o), BW'(n));
      chk("rnd_queue_empty", BW'(exp_q.size()), BW'(0));
    end
    rnd_mode = 1'b0;
    enable_i = 1'b1;
    block_ready_i = 1'b1;
    tick();

    chk("final_queue_empty", BW'(exp_q.size()), BW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish before 5ms");
    $fatal(1);
  end

endmodule
